// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
// Module   : mdu_controller
// Purpose  : MIPS EX-stage multiply/divide unit. Decodes the R-type MDU
//            function codes, runs iterative shift-add multiply or restoring
//            divide over WIDTH bits, owns the HI/LO registers and stalls the
//            pipeline while an operation is in flight.
// Ports    : clk, rst (async, active-high)
//            op, func, start : instruction decode inputs
//            a, b            : rs / rt operands
//            result          : HI for mfhi, LO for mflo, else 0
//            busy, stall     : operation in flight / hold EX
//            done            : one-cycle pulse after HI/LO update
// Revision : 1.0 - initial release
// ============================================================================
module mdu_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [5:0]       func,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;

    localparam logic [5:0] c_f_mfhi  = 6'b010000;
    localparam logic [5:0] c_f_mthi  = 6'b010001;
    localparam logic [5:0] c_f_mflo  = 6'b010010;
    localparam logic [5:0] c_f_mtlo  = 6'b010011;
    localparam logic [5:0] c_f_mult  = 6'b011000;
    localparam logic [5:0] c_f_multu = 6'b011001;
    localparam logic [5:0] c_f_div   = 6'b011010;
    localparam logic [5:0] c_f_divu  = 6'b011011;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_rem;   // mult: upper product half; div: partial remainder
    logic [WIDTH-1:0]   r_q;     // mult: multiplier/lower half; div: dividend/quotient
    logic [WIDTH-1:0]   r_opnd;  // multiplicand or divisor magnitude
    logic               r_is_mul;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_done;

    logic               w_valid;
    logic               w_is_mdu;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_valid  = start && (op == 2'b11);
    // All eight MDU codes share func[5:4]=01 and func[2]=0.
    assign w_is_mdu = w_valid && (func[5:4] == 2'b01) && !func[2];
    // mult and div are the even codes of their pairs.
    assign w_signed = !func[0];

    // Most-negative input maps onto itself, which read unsigned is the
    // correct magnitude; this also yields the wrap-around overflow result.
    assign w_a_mag = (w_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_b_mag = (w_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // Shift-add step: conditionally add multiplicand into the upper half.
    assign w_add = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Restoring divide step: trial subtract, keep result when non-negative.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_opnd};

    assign w_prod     = {r_rem, r_q};
    assign w_prod_fix = r_neg_lo ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

    assign busy  = (r_state != c_idle);
    assign stall = w_is_mdu && busy;
    assign done  = r_done;

    always_comb begin
        result = '0;
        if (w_valid && func == c_f_mfhi) begin
            result = r_hi;
        end else if (w_valid && func == c_f_mflo) begin
            result = r_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_opnd   <= '0;
            r_is_mul <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == c_fix);
            case (r_state)
                c_idle: begin
                    if (w_valid) begin
                        case (func)
                            c_f_mthi: r_hi <= a;
                            c_f_mtlo: r_lo <= a;
                            c_f_mult, c_f_multu: begin
                                r_is_mul <= 1'b1;
                                r_rem    <= '0;
                                r_q      <= w_b_mag;
                                r_opnd   <= w_a_mag;
                                r_neg_lo <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_neg_hi <= 1'b0;
                                r_cnt    <= c_cnt_w'(WIDTH - 1);
                                r_state  <= c_calc;
                            end
                            c_f_div, c_f_divu: begin
                                r_is_mul <= 1'b0;
                                r_cnt    <= c_cnt_w'(WIDTH - 1);
                                if (b == '0) begin
                                    // Preload the divide-by-zero answer and
                                    // let FIX pass it through unchanged.
                                    r_rem    <= a;
                                    r_q      <= '1;
                                    r_opnd   <= '0;
                                    r_neg_lo <= 1'b0;
                                    r_neg_hi <= 1'b0;
                                    r_state  <= c_fix;
                                end else begin
                                    r_rem    <= '0;
                                    r_q      <= w_a_mag;
                                    r_opnd   <= w_b_mag;
                                    r_neg_lo <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    r_neg_hi <= w_signed && a[WIDTH-1];
                                    r_state  <= c_calc;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                c_calc: begin
                    if (r_is_mul) begin
                        {r_rem, r_q} <= {w_add, r_q[WIDTH-1:1]};
                    end else begin
                        r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= c_fix;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_fix: begin
                    if (r_is_mul) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else begin
                        r_lo <= r_neg_lo ? (~r_q + WIDTH'(1)) : r_q;
                        r_hi <= r_neg_hi ? (~r_rem + WIDTH'(1)) : r_rem;
                    end
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_controller
// Purpose  : Self-checking bench for mdu_controller (WIDTH=32): directed
//            scenarios plus randomized mult/div traffic against an
//            arithmetic reference model of HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_controller;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic         clk;
    logic         rst;
    logic [1:0]   op;
    logic [5:0]   func;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         busy;
    logic         stall;
    logic         done;

    int n_tests;
    int n_fail;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    mdu_controller #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .func   (func),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .stall  (stall),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO after an MDU arithmetic op, from plain arithmetic.
    task automatic ref_mdu(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        hi = '0;
        lo = '0;
        if (f == F_MULT) begin
            p = sx * sy;
            hi = p[63:32];
            lo = p[31:0];
        end else if (f == F_MULTU) begin
            p = {32'b0, x} * {32'b0, y};
            hi = p[63:32];
            lo = p[31:0];
        end else if (y == '0) begin
            hi = x;
            lo = '1;
        end else if (f == F_DIV) begin
            p = sx / sy;
            lo = p[31:0];
            p = sx % sy;
            hi = p[31:0];
        end else begin
            lo = x / y;
            hi = x % y;
        end
    endtask

    // Issue an op from an idle cycle, run it to completion and stop in the
    // done cycle (no clock edge consumed after done rises).
    task automatic do_mdu(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        int exp_busy;
        logic [W-1:0] eh, el;
        ref_mdu(f, x, y, eh, el);
        exp_busy = ((f == F_DIV || f == F_DIVU) && y == '0) ? 1 : W + 1;
        start = 1'b1; op = 2'b11; func = f; a = x; b = y;
        #1;
        chk("issue_stall", stall, 0);
        tick();
        start = 1'b0; func = '0;
        chk("accept_done_low", done, 0);
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("busy_cycles", cyc, exp_busy);
        chk("done_pulse", done, 1);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic read_hilo(input string tag);
        start = 1'b1; op = 2'b11; func = F_MFHI;
        #1;
        chk({tag, "_hi"}, result, m_hi);
        chk({tag, "_hi_stall"}, stall, 0);
        func = F_MFLO;
        #1;
        chk({tag, "_lo"}, result, m_lo);
        start = 1'b0; func = '0;
    endtask

    initial begin
        int cyc;
        logic [5:0] fsel [4];
        fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;
        n_tests = 0; n_fail = 0;
        m_hi = '0; m_lo = '0;
        rst = 1'b1; start = 1'b0; op = '0; func = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        read_hilo("rst");

        // mthi then mfhi
        start = 1'b1; op = 2'b11; func = F_MTHI; a = 32'h1234_5678;
        #1;
        chk("mthi_stall", stall, 0);
        tick();
        func = F_MFHI;
        #1;
        chk("mfhi_val", result, 32'h1234_5678);
        chk("mfhi_stall", stall, 0);
        m_hi = 32'h1234_5678;
        // mtlo with a non-R op class must be ignored
        op = 2'b10; func = F_MTLO; a = 32'hDEAD_BEEF;
        tick();
        chk("mtlo_ignored_busy", busy, 0);
        read_hilo("mtlo_ign");
        tick();

        // mult -3 * 5
        do_mdu(F_MULT, 32'hFFFF_FFFD, 32'd5);
        read_hilo("mult_neg");
        chk("mult_lo_const", m_lo, 32'hFFFF_FFF1);
        tick();
        chk("done_drop", done, 0);

        do_mdu(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        read_hilo("multu");
        // next op accepted in the done cycle
        do_mdu(F_DIV, 32'hFFFF_FFF9, 32'd2);
        read_hilo("div_neg");
        do_mdu(F_DIVU, 32'h0000_0064, 32'd0);
        read_hilo("divu_zero");
        do_mdu(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo("div_ovf");
        do_mdu(F_DIV, 32'h8000_0001, 32'd0);
        read_hilo("div_zero");
        tick();

        // Back-to-back: mult then mflo held
        start = 1'b1; op = 2'b11; func = F_MULT; a = 32'h0001_2345; b = 32'hFFFF_0007;
        ref_mdu(F_MULT, a, b, m_hi, m_lo);
        tick();
        func = F_ADD;
        #1;
        chk("add_no_stall", stall, 0);
        func = F_MFLO;
        cyc = 0;
        while (busy && cyc < 100) begin
            #1;
            chk("b2b_stall", stall, 1);
            tick();
            cyc++;
        end
        chk("b2b_busy_cycles", cyc, W + 1);
        chk("b2b_done", done, 1);
        chk("b2b_stall_clear", stall, 0);
        chk("b2b_result", result, m_lo);
        start = 1'b0; func = '0;
        tick();

        // Reset during cycle 10 of a divide
        start = 1'b1; op = 2'b11; func = F_DIV; a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0; func = '0;
        repeat (9) tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        m_hi = '0; m_lo = '0;
        read_hilo("async_rst");
        #2;
        rst = 1'b0;
        tick();
        chk("rst_no_done", done, 0);
        chk("rst_idle", busy, 0);
        do_mdu(F_MULT, 32'd6, 32'd7);
        read_hilo("mult_6x7");
        chk("mult_42", m_lo, 32'd42);

        // Randomized traffic, each op issued in the previous op's done cycle
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] x, y;
            logic [5:0] f;
            f = fsel[$urandom_range(0, 3)];
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = '0;
                1: y = W'($urandom_range(1, 9));
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                default: ;
            endcase
            do_mdu(f, x, y);
            read_hilo("rand");
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
